// File: rtl/ntr_cmd_ctrl.sv
// ntr_cmd_ctrl: command controller for the NTR cartridge-bus snooper.
// Takes each assembled 64-bit command, dispatches on the opcode byte and
// sequences the response phase. Read data comes from a backing store over a
// req/valid handshake and goes out one byte per host clock on the NTR bus.
module ntr_cmd_ctrl #(
  parameter int unsigned RESP_LEN = 512,
  parameter int unsigned CNT_W    = 13,
  parameter logic [31:0] CHIP_ID  = 32'hC20F_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] cmd_i,
  input  logic        cmd_ready_i,
  input  logic        ntr_clk_db_i,
  input  logic        ntr_cs1_db_i,
  output logic        fetch_req_o,
  output logic [31:0] fetch_addr_o,
  input  logic [7:0]  fetch_data_i,
  input  logic        fetch_valid_i,
  output logic [7:0]  ntr_dout_o,
  output logic        ntr_oe_o,
  output logic        led_o,
  output logic        busy_o,
  output logic        underrun_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_SEND   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [7:0] OP_LED    = 8'hFF;
  localparam logic [7:0] OP_CHIPID = 8'h90;
  localparam logic [7:0] OP_READ   = 8'hB7;

  logic [2:0]       state_q, state_d;
  logic [63:0]      cmd_q, cmd_d;
  logic [31:0]      base_q, base_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             clk_prev_q;
  logic             led_q, led_d;
  logic             oe_q, oe_d;
  logic [7:0]       dout_q, dout_d;
  logic             req_q, req_d;
  logic [31:0]      faddr_q, faddr_d;
  logic             underrun_q, underrun_d;
  // Set while the request in flight belongs to a byte the host already
  // consumed; its data is dropped and the current index is fetched instead.
  logic             discard_q, discard_d;

  logic             rise;
  logic             abort;
  logic [CNT_W-1:0] idx_inc;
  logic             last;
  logic [7:0]       opcode;
  logic [31:0]      read_base;
  logic             unused_cmd_bits;

  assign rise      = ntr_clk_db_i & ~clk_prev_q;
  assign abort     = ntr_cs1_db_i | ~cmd_ready_i;
  assign idx_inc   = idx_q + CNT_W'(1);
  assign last      = (idx_inc == len_q);
  assign opcode    = cmd_q[7:0];
  assign read_base = {cmd_q[15:8], cmd_q[23:16], cmd_q[31:24], cmd_q[39:32]};
  assign unused_cmd_bits = ^{cmd_q[63:57], cmd_q[55:40]};

  // Next-state logic for the command FSM and every registered output.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    base_d     = base_q;
    idx_d      = idx_q;
    len_d      = len_q;
    led_d      = led_q;
    oe_d       = oe_q;
    dout_d     = dout_q;
    req_d      = req_q;
    faddr_d    = faddr_q;
    underrun_d = underrun_q;
    discard_d  = discard_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_ready_i) begin
          cmd_d   = cmd_i;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (!cmd_ready_i) begin
          state_d = S_DONE;
        end else begin
          case (opcode)
            OP_LED: begin
              led_d   = cmd_q[56];
              state_d = S_DONE;
            end
            OP_CHIPID: begin
              idx_d   = '0;
              len_d   = CNT_W'(4);
              dout_d  = CHIP_ID[7:0];
              oe_d    = 1'b1;
              state_d = S_SEND;
            end
            OP_READ: begin
              base_d    = read_base;
              idx_d     = '0;
              len_d     = CNT_W'(RESP_LEN);
              req_d     = 1'b1;
              faddr_d   = read_base;
              discard_d = 1'b0;
              state_d   = S_FETCH;
            end
            default: begin
              state_d = S_DONE;
            end
          endcase
        end
      end

      S_FETCH: begin
        if (abort) begin
          oe_d    = 1'b0;
          state_d = S_DONE;
          if (fetch_valid_i) begin
            req_d     = 1'b0;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (rise) begin
          underrun_d = 1'b1;
          idx_d      = idx_inc;
          if (last) begin
            oe_d    = 1'b0;
            state_d = S_DONE;
            if (fetch_valid_i) begin
              req_d     = 1'b0;
              discard_d = 1'b0;
            end else begin
              discard_d = 1'b1;
            end
          end else if (fetch_valid_i) begin
            faddr_d   = base_q + 32'(idx_inc);
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (fetch_valid_i) begin
          if (discard_q) begin
            faddr_d   = base_q + 32'(idx_q);
            discard_d = 1'b0;
          end else begin
            dout_d  = fetch_data_i;
            oe_d    = 1'b1;
            req_d   = 1'b0;
            state_d = S_SEND;
          end
        end
      end

      S_SEND: begin
        if (abort) begin
          oe_d    = 1'b0;
          state_d = S_DONE;
        end else if (rise) begin
          idx_d = idx_inc;
          if (last) begin
            oe_d    = 1'b0;
            state_d = S_DONE;
          end else if (opcode == OP_CHIPID) begin
            dout_d = CHIP_ID[{idx_inc[1:0], 3'b000} +: 8];
          end else begin
            req_d   = 1'b1;
            faddr_d = base_q + 32'(idx_inc);
            state_d = S_FETCH;
          end
        end
      end

      S_DONE: begin
        oe_d = 1'b0;
        if (req_q && fetch_valid_i) begin
          req_d     = 1'b0;
          discard_d = 1'b0;
        end
        if (!cmd_ready_i && !req_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; clk_prev resets high so a bus clock that is
  // already high at reset release is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      base_q     <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      clk_prev_q <= 1'b1;
      led_q      <= 1'b0;
      oe_q       <= 1'b0;
      dout_q     <= 8'h00;
      req_q      <= 1'b0;
      faddr_q    <= '0;
      underrun_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      clk_prev_q <= ntr_clk_db_i;
      led_q      <= led_d;
      oe_q       <= oe_d;
      dout_q     <= dout_d;
      req_q      <= req_d;
      faddr_q    <= faddr_d;
      underrun_q <= underrun_d;
      discard_q  <= discard_d;
    end
  end

  assign fetch_req_o  = req_q;
  assign fetch_addr_o = faddr_q;
  assign ntr_dout_o   = dout_q;
  assign ntr_oe_o     = oe_q;
  assign led_o        = led_q;
  assign busy_o       = (state_q != S_IDLE);
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_ntr_cmd_ctrl.sv
// tb_ntr_cmd_ctrl: scoreboard bench for ntr_cmd_ctrl. Tests push the bytes
// the host should sample and the addresses the store should see; a host-side
// monitor and the store model pop and compare them as the DUT produces them.
module tb_ntr_cmd_ctrl;

  localparam int RESP_LEN = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] cmd_i = '0;
  logic        cmd_ready_i = 1'b0;
  logic        ntr_clk_db_i = 1'b0;
  logic        ntr_cs1_db_i = 1'b0;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic [7:0]  fetch_data_i = 8'h00;
  logic        fetch_valid_i = 1'b0;
  logic [7:0]  ntr_dout_o;
  logic        ntr_oe_o;
  logic        led_o;
  logic        busy_o;
  logic        underrun_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]  expBytes[$];
  logic [31:0] expAddrs[$];

  logic [31:0] slowAddr = 32'hFFFF_FFFF;
  int          slowLat = 2;
  logic        memBusy = 1'b0;
  logic [31:0] memAddr = '0;
  int          memCnt = 0;

  ntr_cmd_ctrl #(.RESP_LEN(RESP_LEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_i        (cmd_i),
    .cmd_ready_i  (cmd_ready_i),
    .ntr_clk_db_i (ntr_clk_db_i),
    .ntr_cs1_db_i (ntr_cs1_db_i),
    .fetch_req_o  (fetch_req_o),
    .fetch_addr_o (fetch_addr_o),
    .fetch_data_i (fetch_data_i),
    .fetch_valid_i(fetch_valid_i),
    .ntr_dout_o   (ntr_dout_o),
    .ntr_oe_o     (ntr_oe_o),
    .led_o        (led_o),
    .busy_o       (busy_o),
    .underrun_o   (underrun_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Backing store: answers each request with addr[7:0] after slowLat cycles
  // for slowAddr, 2 cycles otherwise, and checks the requested address.
  always @(posedge clk) begin
    #1;
    fetch_valid_i = 1'b0;
    if (!rst_n) begin
      memBusy = 1'b0;
    end else if (memBusy) begin
      if (memCnt == 0) begin
        fetch_valid_i = 1'b1;
        fetch_data_i  = memAddr[7:0];
        memBusy       = 1'b0;
        if (expAddrs.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL fetch_addr unexpected: got 0x%0h, expected none", memAddr);
        end else begin
          checkOutput("fetch_addr", memAddr, expAddrs.pop_front());
        end
      end else begin
        memCnt--;
      end
    end else if (fetch_req_o) begin
      memBusy = 1'b1;
      memAddr = fetch_addr_o;
      memCnt  = ((fetch_addr_o == slowAddr) ? slowLat : 2) - 1;
    end
  end

  // Host monitor: on each host clock rise with the bus driven, compare the byte.
  always @(posedge ntr_clk_db_i) begin
    if (ntr_oe_o) begin
      if (expBytes.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL host byte unexpected: got 0x%0h, expected none", ntr_dout_o);
      end else begin
        checkOutput("host byte", {24'h0, ntr_dout_o}, {24'h0, expBytes.pop_front()});
      end
    end
  end

  task automatic applyStimulus(input logic [63:0] c);
    @(negedge clk);
    cmd_i       = c;
    cmd_ready_i = 1'b1;
  endtask

  task automatic releaseCmd();
    @(negedge clk);
    cmd_ready_i = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One host clock: 10 cycles low, 10 high, ending on the falling edge.
  task automatic hostClocks(input int n);
    for (int i = 0; i < n; i++) begin
      waitCycles(10);
      ntr_clk_db_i = 1'b1;
      waitCycles(10);
      ntr_clk_db_i = 1'b0;
    end
  endtask

  task automatic expectAddrs(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) expAddrs.push_back(first + 32'(i));
  endtask

  task automatic expectBytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) expBytes.push_back(first + 8'(i));
  endtask

  task automatic checkDrained(input string name);
    checkOutput({name, " bytes left"}, expBytes.size(), 0);
    checkOutput({name, " addrs left"}, expAddrs.size(), 0);
  endtask

  task automatic finishRead(input string name);
    checkOutput({name, " oe after last"}, ntr_oe_o, 1'b0);
    releaseCmd();
    waitCycles(2);
    checkOutput({name, " busy idle"}, busy_o, 1'b0);
    checkDrained(name);
  endtask

  localparam logic [63:0] READ_CMD = 64'h0000_0000_1000_00B7;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    waitCycles(3);
    checkOutput("reset led", led_o, 1'b0);
    checkOutput("reset oe", ntr_oe_o, 1'b0);
    checkOutput("reset dout", ntr_dout_o, 8'h00);
    checkOutput("reset req", fetch_req_o, 1'b0);
    checkOutput("reset addr", fetch_addr_o, 32'h0);
    checkOutput("reset busy", busy_o, 1'b0);
    checkOutput("reset underrun", underrun_o, 1'b0);
    rst_n = 1'b1;
    waitCycles(2);

    $display("[TB] LED commands");
    applyStimulus(64'h0100_0000_0000_00FF);
    waitCycles(3);
    checkOutput("led on", led_o, 1'b1);
    checkOutput("led oe", ntr_oe_o, 1'b0);
    checkOutput("led busy", busy_o, 1'b1);
    releaseCmd();
    waitCycles(2);
    checkOutput("led busy drop", busy_o, 1'b0);
    applyStimulus(64'h0000_0000_0000_00FF);
    waitCycles(3);
    checkOutput("led off", led_o, 1'b0);
    checkOutput("led off oe", ntr_oe_o, 1'b0);
    releaseCmd();
    waitCycles(2);
    checkOutput("led off busy", busy_o, 1'b0);

    $display("[TB] Chip ID");
    expBytes.push_back(8'h00);
    expBytes.push_back(8'h00);
    expBytes.push_back(8'h0F);
    expBytes.push_back(8'hC2);
    applyStimulus(64'h0000_0000_0000_0090);
    waitCycles(3);
    checkOutput("chipid oe", ntr_oe_o, 1'b1);
    hostClocks(3);
    waitCycles(10);
    ntr_clk_db_i = 1'b1;
    waitCycles(1);
    checkOutput("chipid oe falls", ntr_oe_o, 1'b0);
    checkOutput("chipid busy", busy_o, 1'b1);
    ntr_clk_db_i = 1'b0;
    releaseCmd();
    waitCycles(2);
    checkOutput("chipid busy drop", busy_o, 1'b0);
    checkDrained("chipid");

    $display("[TB] Read");
    expectAddrs(32'h1000, 8);
    expectBytes(8'h00, 8);
    applyStimulus(READ_CMD);
    waitCycles(2);
    hostClocks(8);
    checkOutput("read underrun", underrun_o, 1'b0);
    finishRead("read");

    $display("[TB] Abort");
    expectAddrs(32'h1000, 4);
    expectBytes(8'h00, 3);
    slowAddr = 32'h1003;
    slowLat  = 30;
    applyStimulus(READ_CMD);
    waitCycles(2);
    hostClocks(3);
    waitCycles(1);
    ntr_cs1_db_i = 1'b1;
    waitCycles(1);
    checkOutput("abort oe", ntr_oe_o, 1'b0);
    checkOutput("abort req pending", fetch_req_o, 1'b1);
    checkOutput("abort busy", busy_o, 1'b1);
    for (int i = 0; i < 60 && !fetch_valid_i; i++) @(negedge clk);
    checkOutput("abort fetch completes", fetch_valid_i, 1'b1);
    waitCycles(1);
    checkOutput("abort req drop", fetch_req_o, 1'b0);
    checkOutput("abort data discarded", ntr_oe_o, 1'b0);
    ntr_cs1_db_i = 1'b0;
    slowAddr = 32'hFFFF_FFFF;
    releaseCmd();
    waitCycles(2);
    checkOutput("abort busy drop", busy_o, 1'b0);
    checkDrained("abort");

    $display("[TB] Underrun");
    expectAddrs(32'h1000, 8);
    expBytes.push_back(8'h00);
    expBytes.push_back(8'h01);
    expBytes.push_back(8'h01);
    expectBytes(8'h03, 5);
    slowAddr = 32'h1002;
    slowLat  = 22;
    applyStimulus(READ_CMD);
    waitCycles(2);
    hostClocks(8);
    slowAddr = 32'hFFFF_FFFF;
    checkOutput("underrun set", underrun_o, 1'b1);
    finishRead("underrun");
    checkOutput("underrun sticky", underrun_o, 1'b1);

    $display("[TB] Reset mid-stream");
    applyStimulus(64'h0100_0000_0000_00FF);
    waitCycles(3);
    releaseCmd();
    waitCycles(2);
    checkOutput("pre-reset led", led_o, 1'b1);
    expectAddrs(32'h1000, 3);
    expectBytes(8'h00, 2);
    applyStimulus(READ_CMD);
    waitCycles(2);
    hostClocks(2);
    checkOutput("pre-reset oe", ntr_oe_o, 1'b1);
    checkOutput("pre-reset underrun", underrun_o, 1'b1);
    #2;
    rst_n       = 1'b0;
    cmd_ready_i = 1'b0;
    #1;
    checkOutput("async reset led", led_o, 1'b0);
    checkOutput("async reset oe", ntr_oe_o, 1'b0);
    checkOutput("async reset dout", ntr_dout_o, 8'h00);
    checkOutput("async reset req", fetch_req_o, 1'b0);
    checkOutput("async reset addr", fetch_addr_o, 32'h0);
    checkOutput("async reset busy", busy_o, 1'b0);
    checkOutput("async reset underrun", underrun_o, 1'b0);
    checkDrained("reset");
    waitCycles(1);
    rst_n = 1'b1;
    waitCycles(2);

    expectAddrs(32'h1000, 8);
    expectBytes(8'h00, 8);
    applyStimulus(READ_CMD);
    waitCycles(2);
    hostClocks(8);
    checkOutput("post-reset underrun", underrun_o, 1'b0);
    finishRead("post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
